// File: rtl/thresh_pkg.sv
// Shared definitions for the streaming thresholding engine: FSM encoding,
// mode constants and pipeline latency. Soft mode is built only with THRESH_SOFT_EN.
package thresh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic MODE_HARD = 1'b0;
  localparam logic MODE_SOFT = 1'b1;

  localparam int THRESH_LAT = 2;

endpackage

// File: rtl/thresh_core.sv
// Two-stage thresholding datapath: magnitude/compare, then output select.
// The soft-threshold subtractor and sign restore exist only under THRESH_SOFT_EN.
module thresh_core
  import thresh_pkg::*;
#(
  parameter int W   = 12,
  parameter int IDW = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] sample,
  input  logic [W-2:0]        thr,
  input  logic                mode,
  input  logic                valid,
  input  logic [IDW-1:0]      idx,
  output logic signed [W-1:0] y,
  output logic                done,
  output logic [IDW-1:0]      id,
  output logic                nz
);

  logic [W-1:0]   raw, mag, thr_ext;
  logic           valid1_d, valid1_q, pass1_d, pass1_q;
  logic [W-1:0]   sig1_d, sig1_q;
  logic [IDW-1:0] id1_d, id1_q;
  logic [W-1:0]   y_d, y_q;
  logic           done_d, done_q, nz_d, nz_q;
  logic [IDW-1:0] id_d, id_q;
`ifdef THRESH_SOFT_EN
  logic [W-1:0]   diff1_d, diff1_q;
  logic           neg1_d, neg1_q, soft1_d, soft1_q;
`else
  logic           unused_mode;
  assign unused_mode = mode;
`endif

  // Magnitude is unsigned W bits so the most negative sample maps to 2^(W-1).
  always_comb begin
    raw      = sample;
    mag      = raw[W-1] ? ('0 - raw) : raw;
    thr_ext  = {1'b0, thr};
    valid1_d = valid;
    pass1_d  = (mag > thr_ext);
    sig1_d   = raw;
    id1_d    = idx;
`ifdef THRESH_SOFT_EN
    diff1_d  = mag - thr_ext;
    neg1_d   = raw[W-1];
    soft1_d  = (mode == MODE_SOFT);
`endif
  end

  always_comb begin
    y_d    = y_q;
    id_d   = id_q;
    done_d = valid1_q;
    nz_d   = 1'b0;
    if (valid1_q) begin
      id_d = id1_q;
      if (!pass1_q) y_d = '0;
`ifdef THRESH_SOFT_EN
      else if (soft1_q) y_d = neg1_q ? ('0 - diff1_q) : diff1_q;
`endif
      else y_d = sig1_q;
      nz_d = (y_d != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid1_q <= 1'b0;
      pass1_q  <= 1'b0;
      sig1_q   <= '0;
      id1_q    <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      id_q     <= '0;
      nz_q     <= 1'b0;
`ifdef THRESH_SOFT_EN
      diff1_q  <= '0;
      neg1_q   <= 1'b0;
      soft1_q  <= 1'b0;
`endif
    end else begin
      valid1_q <= valid1_d;
      pass1_q  <= pass1_d;
      sig1_q   <= sig1_d;
      id1_q    <= id1_d;
      y_q      <= y_d;
      done_q   <= done_d;
      id_q     <= id_d;
      nz_q     <= nz_d;
`ifdef THRESH_SOFT_EN
      diff1_q  <= diff1_d;
      neg1_q   <= neg1_d;
      soft1_q  <= soft1_d;
`endif
    end
  end

  assign y    = $signed(y_q);
  assign done = done_q;
  assign id   = id_q;
  assign nz   = nz_q;

endmodule

// File: rtl/thresh_stream.sv
// Frame-level control for the thresholding engine: FSM, sample counter, input
// capture and per-frame non-zero count. Soft mode requires THRESH_SOFT_EN.
module thresh_stream
  import thresh_pkg::*;
#(
  parameter int W   = 12,
  parameter int N   = 2048,
  parameter int IDW = 12,
  parameter int CW  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [W-2:0]        thr,
  input  logic                mode,
  input  logic                in_valid,
  input  logic signed [W-1:0] sig,
  output logic signed [W-1:0] y,
  output logic                done,
  output logic [IDW-1:0]      id,
  output logic                busy,
  output logic                frame_done,
  output logic [CW-1:0]       nz_cnt
);

  localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

  state_e                state_d, state_q;
  logic [IDW-1:0]        cnt_d, cnt_q, idx_d, idx_q;
  logic [W-2:0]          thr_d, thr_q;
  logic                  mode_d, mode_q, acc_d, acc_q, accept;
  logic [W-1:0]          samp_d, samp_q;
  logic [THRESH_LAT-1:0] last_d, last_q;
  logic                  frame_done_d, frame_done_q, busy_d, busy_q;
  logic [CW-1:0]         run_cnt_d, run_cnt_q, nz_cnt_d, nz_cnt_q;
  logic signed [W-1:0]   core_y;
  logic                  core_done, core_nz;
  logic [IDW-1:0]        core_id;

  // A start in the frame_done cycle overrides the busy clear, giving back-to-back frames.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    thr_d     = thr_q;
    mode_d    = mode_q;
    accept    = 1'b0;
    run_cnt_d = run_cnt_q + CW'(core_nz);
    nz_cnt_d  = frame_done_q ? (run_cnt_q + CW'(core_nz)) : nz_cnt_q;
    busy_d    = frame_done_q ? 1'b0 : busy_q;
    unique case (state_q)
      ST_IDLE: if (enable) begin
        state_d   = ST_RUN;
        thr_d     = thr;
        mode_d    = mode;
        cnt_d     = '0;
        run_cnt_d = '0;
        busy_d    = 1'b1;
      end
      ST_RUN: if (in_valid) begin
        accept = 1'b1;
        cnt_d  = cnt_q + IDW'(1);
        if (cnt_q == LAST_IDX) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (last_q[THRESH_LAT-1]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    samp_d       = accept ? sig : samp_q;
    acc_d        = accept;
    idx_d        = accept ? cnt_q : idx_q;
    last_d       = {last_q[THRESH_LAT-2:0], accept && (cnt_q == LAST_IDX)};
    frame_done_d = last_q[THRESH_LAT-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      thr_q        <= '0;
      mode_q       <= MODE_HARD;
      samp_q       <= '0;
      acc_q        <= 1'b0;
      idx_q        <= '0;
      last_q       <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      run_cnt_q    <= '0;
      nz_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      thr_q        <= thr_d;
      mode_q       <= mode_d;
      samp_q       <= samp_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      run_cnt_q    <= run_cnt_d;
      nz_cnt_q     <= nz_cnt_d;
    end
  end

  thresh_core #(.W(W), .IDW(IDW)) u_core (
    .clk    (clk),
    .reset  (reset),
    .sample (samp_q),
    .thr    (thr_q),
    .mode   (mode_q),
    .valid  (acc_q),
    .idx    (idx_q),
    .y      (core_y),
    .done   (core_done),
    .id     (core_id),
    .nz     (core_nz)
  );

  assign y          = core_y;
  assign done       = core_done;
  assign id         = core_id;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign nz_cnt     = nz_cnt_q;

endmodule

// File: tb/tb_thresh_stream.sv
// Directed bench for thresh_stream: small N=8 instance for frame-level scenarios,
// default-parameter instance for back-to-back frames against a golden model.
module tb_thresh_stream;

  localparam int W = 12, N = 8, IDW = 3, CW = 4;
  localparam int NB = 2048;
  localparam bit SOFT_ON =
`ifdef THRESH_SOFT_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                enable = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [W-2:0]        thr = '0;
  logic signed [W-1:0] sig = '0;
  logic signed [W-1:0] y;
  logic                done, busy, frame_done;
  logic [IDW-1:0]      id;
  logic [CW-1:0]       nz_cnt;

  logic                en2 = 1'b0, mode2 = 1'b0, inv2 = 1'b0;
  logic [10:0]         thr2 = '0;
  logic signed [11:0]  sig2 = '0;
  logic signed [11:0]  y2;
  logic                done2, busy2, fd2;
  logic [11:0]         id2, nz2;

  thresh_stream #(.W(W), .N(N), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .thr(thr), .mode(mode),
    .in_valid(in_valid), .sig(sig), .y(y), .done(done), .id(id),
    .busy(busy), .frame_done(frame_done), .nz_cnt(nz_cnt)
  );

  thresh_stream dut2 (
    .clk(clk), .reset(reset), .enable(en2), .thr(thr2), .mode(mode2),
    .in_valid(inv2), .sig(sig2), .y(y2), .done(done2), .id(id2),
    .busy(busy2), .frame_done(fd2), .nz_cnt(nz2)
  );

  int total = 0, bad = 0, edge_no = 0, fd2_cnt = 0;
  logic signed [11:0] got_y[$], got2_y[$], exp2_y[$];
  int got_id[$], got_edge[$], fd_edge[$], exp_edge[$];
  logic fd_busy[$];

  logic signed [11:0] samp_a[8] = '{12'sd50, -12'sd150, 12'sd100, 12'sd101,
                                    -12'sd100, 12'sd0, 12'sd2047, 12'sh800};
  logic signed [11:0] hard_a[8] = '{12'sd0, -12'sd150, 12'sd0, 12'sd101,
                                    12'sd0, 12'sd0, 12'sd2047, 12'sh800};
  logic signed [11:0] soft_a[8] = '{12'sd0, -12'sd50, 12'sd0, 12'sd1,
                                    12'sd0, 12'sd0, 12'sd1947, -12'sd1948};
  logic signed [11:0] samp_e[8] = '{12'sh800, 12'sd5, -12'sd5, 12'sd0,
                                    12'sd1, -12'sd1, 12'sd2047, -12'sd2047};
  logic signed [11:0] s1[NB], s2[NB];

  // Outputs are sampled 1 time unit after each rising edge and tagged with the edge number.
  always @(posedge clk) begin
    edge_no++;
    #1;
    if (done) begin
      got_y.push_back(y);
      got_id.push_back(int'(id));
      got_edge.push_back(edge_no);
    end
    if (frame_done) begin
      fd_edge.push_back(edge_no);
      fd_busy.push_back(busy);
    end
    if (done2) got2_y.push_back(y2);
    if (fd2) fd2_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic signed [11:0] model_y(input logic signed [11:0] s,
                                                 input logic [10:0] t, input logic m);
    logic [11:0] a, d;
    a = s[11] ? (12'd0 - 12'(s)) : 12'(s);
    if (a <= {1'b0, t}) return 12'sd0;
    if (m && SOFT_ON) begin
      d = a - {1'b0, t};
      return s[11] ? $signed(12'd0 - d) : $signed(d);
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One N=8 frame; gap inserts stall cycles after each valid, early drives in_valid with enable.
  task automatic applyStimulus(input logic [W-2:0] t, input logic m,
                               input logic signed [11:0] s[8], input int gap,
                               input logic early);
    exp_edge.delete();
    @(negedge clk);
    enable = 1'b1; thr = t; mode = m; in_valid = early; sig = 12'sd77;
    @(negedge clk);
    enable = 1'b0; thr = ~t; mode = ~m;
    checkOutput("busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; sig = s[i];
      exp_edge.push_back(edge_no + 3);
      @(negedge clk);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; sig = 12'sd99;
        @(negedge clk);
      end
    end
    in_valid = 1'b1; sig = 12'sd55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkFrame(input string name, input logic signed [11:0] ey[8],
                            input int nz);
    checkOutput({name, "_ndone"}, 32'(got_y.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_y.size()) begin
        checkOutput($sformatf("%s_y%0d", name, i), 32'(got_y[i]), 32'(ey[i]));
        checkOutput($sformatf("%s_id%0d", name, i), 32'(got_id[i]), 32'(i));
        checkOutput($sformatf("%s_edge%0d", name, i), 32'(got_edge[i]), 32'(exp_edge[i]));
      end
    end
    checkOutput({name, "_nfd"}, 32'(fd_edge.size()), 32'd1);
    if (fd_edge.size() > 0) begin
      checkOutput({name, "_fd_edge"}, 32'(fd_edge[0]), 32'(exp_edge[7]));
      checkOutput({name, "_fd_busy"}, 32'(fd_busy[0]), 32'd1);
    end
    checkOutput({name, "_nz"}, 32'(nz_cnt), 32'(nz));
    checkOutput({name, "_busy_end"}, 32'(busy), 32'd0);
    got_y.delete(); got_id.delete(); got_edge.delete();
    fd_edge.delete(); fd_busy.delete();
  endtask

  initial begin
    int w, nz1_exp, nz2_exp;
    repeat (2) @(negedge clk);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_id", 32'(id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fd", 32'(frame_done), 32'd0);
    checkOutput("rst_nz", 32'(nz_cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(11'd100, 1'b0, samp_a, 0, 1'b0);
    checkFrame("hard", hard_a, 4);

    applyStimulus(11'd100, 1'b1, samp_a, 0, 1'b0);
    checkFrame("soft", SOFT_ON ? soft_a : hard_a, 4);

    applyStimulus(11'd100, 1'b0, samp_a, 2, 1'b0);
    checkFrame("stall", hard_a, 4);

    applyStimulus(11'd0, 1'b1, samp_e, 0, 1'b1);
    checkFrame("edge", samp_e, 7);

    @(negedge clk);
    enable = 1'b1; thr = 11'd100; mode = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sig = samp_a[i];
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_y", 32'(y), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_id", 32'(id), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_fd", 32'(frame_done), 32'd0);
    checkOutput("mid_rst_nz", 32'(nz_cnt), 32'd0);
    got_y.delete(); got_id.delete(); got_edge.delete();
    fd_edge.delete(); fd_busy.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mid_rst_no_done", 32'(got_y.size()), 32'd0);
    checkOutput("mid_rst_no_fd", 32'(fd_edge.size()), 32'd0);
    applyStimulus(11'd100, 1'b0, samp_a, 0, 1'b0);
    checkFrame("after_rst", hard_a, 4);

    nz1_exp = 0; nz2_exp = 0;
    for (int i = 0; i < NB; i++) begin
      s1[i] = 12'($urandom_range(0, 4095));
      s2[i] = 12'($urandom_range(0, 4095));
    end
    s1[0] = 12'sh800; s1[1] = 12'sd2047; s1[2] = 12'sd300; s1[3] = -12'sd301;
    for (int i = 0; i < NB; i++) begin
      exp2_y.push_back(model_y(s1[i], 11'd300, 1'b0));
      if (model_y(s1[i], 11'd300, 1'b0) != 12'sd0) nz1_exp++;
    end
    for (int i = 0; i < NB; i++) begin
      exp2_y.push_back(model_y(s2[i], 11'd1000, 1'b1));
      if (model_y(s2[i], 11'd1000, 1'b1) != 12'sd0) nz2_exp++;
    end

    @(negedge clk);
    en2 = 1'b1; thr2 = 11'd300; mode2 = 1'b0;
    @(negedge clk);
    en2 = 1'b0;
    for (int i = 0; i < NB; i++) begin
      inv2 = 1'b1; sig2 = s1[i];
      if (i == 1000) thr2 = 11'd1500;
      @(negedge clk);
    end
    inv2 = 1'b0;
    w = 0;
    while (fd2_cnt < 1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("big_fd1_seen", 32'(fd2_cnt), 32'd1);
    @(negedge clk);
    checkOutput("big_nz1", 32'(nz2), 32'(nz1_exp));
    en2 = 1'b1; thr2 = 11'd1000; mode2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    for (int i = 0; i < NB; i++) begin
      inv2 = 1'b1; sig2 = s2[i];
      @(negedge clk);
    end
    inv2 = 1'b0;
    w = 0;
    while (fd2_cnt < 2 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    checkOutput("big_fd_count", 32'(fd2_cnt), 32'd2);
    checkOutput("big_nz2", 32'(nz2), 32'(nz2_exp));
    checkOutput("big_ndone", 32'(got2_y.size()), 32'(2 * NB));
    for (int i = 0; i < 2 * NB; i++) begin
      if (i < got2_y.size())
        checkOutput($sformatf("big_y%0d", i), 32'(got2_y[i]), 32'(exp2_y[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thresh_stream.md
# thresh_stream

Parametrised streaming thresholding engine for the compressed-sensing ECG path: it takes one frame of N signed coefficients and outputs each coefficient hard- or soft-thresholded against a threshold latched at frame start. It is the generalised successor of the fixed 12-bit / 2048-sample `thresholding` block, and adds:
- configurable width and frame length;
- an input valid qualifier that allows stalls;
- a runtime hard/soft mode;
- per-frame sparsity (non-zero) count for the downstream compressor.

## Interface
Parameters:
- W, 12, sample width (signed two's complement), W ≥ 4
- N, 2048, samples per frame, N ≥ 2
- IDW, 12, index width, must satisfy 2^IDW ≥ N
- CW, 12, non-zero count width, must satisfy 2^CW ≥ N+1

Ports (timing is defined under Timing):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  frame start request
- thr  in  W-1  unsigned magnitude threshold
- mode  in  1  0 = hard, 1 = soft
- in_valid  in  1  sig qualifier
- sig  in  W  signed input coefficient
- y  out  W  signed thresholded coefficient
- done  out  1  output valid strobe for y/id
- id  out  IDW  index of the sample on y, 0..N-1
- busy  out  1  high from the accepting edge through the frame_done cycle
- frame_done  out  1  single-cycle pulse, coincident with done for sample N-1
- nz_cnt  out  CW  number of non-zero y values in the last completed frame

## Operation
State machine (IDLE, RUN, FLUSH):
- **IDLE:**
  - `enable` sampled high latches `thr`, `mode` and clears the sample counter and running non-zero count.
  - Next state is RUN.
  - `in_valid` is ignored in IDLE, including in the cycle that `enable` is sampled.
- **RUN:**
  - A sample is accepted on every edge with `in_valid`=1.
  - The accepted sample is tagged with index = counter, then the counter increments.
  - Acceptance of index N-1 moves the state to FLUSH.
  - Cycles with `in_valid`=0 are stall cycles: no acceptance, counter holds.
- **FLUSH:**
  - `in_valid` is ignored.
  - The state returns to IDLE in the cycle in which the last sample's `done` and `frame_done` are asserted.
- `enable` is ignored while in RUN or FLUSH.
- Back-to-back frames are allowed: an `enable` in the first IDLE cycle after `frame_done` starts a new frame.

Datapath arithmetic:
- Magnitude a = |sig| is computed in W bits unsigned, so -2^(W-1) yields 2^(W-1) with no overflow.
- Pass condition: a > thr (strict). A sample that fails the condition gives y = 0.
- Hard mode, on pass: y = sig.
- Soft mode, on pass: y = sign(sig)·(a − thr).
  - a − thr is always less than 2^(W-1) except at sig = −2^(W-1) with thr = 0, which gives −2^(W-1). That value is representable, so no saturation logic is required.
- Non-zero count: incremented for each output with y ≠ 0. `nz_cnt` is loaded with the final value on `frame_done` and holds until the next `frame_done`.

## Timing
- Latency is 2 cycles. A sample accepted at edge k appears on `y`/`id` with `done`=1 after edge k+2.
- Stall bubbles propagate: `done` mirrors the acceptance pattern delayed by 2 cycles.
- `frame_done` asserts in the cycle `done` is high for id N-1.
- `busy` rises on the edge that samples `enable` in IDLE and falls on the edge after the `frame_done` cycle.
- Reset values, all outputs: `y`=0, `done`=0, `id`=0, `busy`=0, `frame_done`=0, `nz_cnt`=0. State returns to IDLE.
- Reset asserted mid-frame discards all in-flight samples. No `done` or `frame_done` is produced for the aborted frame, and `nz_cnt` returns to 0.
- Changes to `thr` or `mode` during a frame have no effect until the next `enable`.
- `y` and `id` hold their last values while `done`=0.

## Configuration
- THRESH_SOFT_EN defined: soft mode is built in and `mode` selects it as described under Operation.
- THRESH_SOFT_EN undefined:
  - the subtractor and sign-restore logic are omitted;
  - the `mode` port remains but is ignored;
  - the block always performs hard thresholding.

## Structure
- Package `thresh_pkg`:
  - state encoding (IDLE/RUN/FLUSH);
  - mode constants MODE_HARD=0 and MODE_SOFT=1;
  - the latency constant THRESH_LAT=2.
- Sub-module `thresh_core`, the two-stage pipelined datapath:
  - inputs: sample, threshold, mode, valid, index;
  - outputs: y, done, id and a non-zero flag.
- The top level holds the FSM, counters and `nz_cnt` register.

## Test plan
All scenarios use W=12 and N=8 unless noted.
- **Hard mode, no stalls.**
  - Stimulus: thr=100, mode=0, sig = {50, −150, 100, 101, −100, 0, 2047, −2048}, `in_valid` held high.
  - Required: y = {0, −150, 0, 101, 0, 0, 2047, −2048}; id = 0..7; `frame_done` with id 7; `nz_cnt`=4.
- **Soft mode, same samples.**
  - Required: y = {0, −50, 0, 1, 0, 0, 1947, −1948}; `nz_cnt`=4.
- **Stalls.**
  - Stimulus: `in_valid` toggled 1,0,0,1,….
  - Required: each `done` lands 2 cycles after its acceptance, ids stay contiguous 0..7, no extra `done`.
- **Edge values and early enable.**
  - Stimulus: thr=0, soft mode, sig=−2048; `enable` and `in_valid` asserted in the same IDLE cycle.
  - Required: y=−2048; the same-cycle sample is not accepted and first id 0 maps to the next valid sample.
- **Reset mid-frame.**
  - Stimulus: assert `reset` low after 5 samples.
  - Required: all outputs at reset values, no `frame_done`; the next frame restarts at id 0.
- **Default parameters and back-to-back frames.**
  - Stimulus: default N=2048, two back-to-back frames, `thr` changed mid-frame 1.
  - Required: frame 1 uses its latched `thr`; `frame_done` exactly twice; `nz_cnt` matches the golden model output.
